// File: rtl/banked_store_reader_if.sv
// rtl/banked_store_reader_if.sv - request, data-store and response bundle for banked_store_reader
//
// Purpose: groups the request, data-store read and response handshakes of
// banked_store_reader into one bundle.
//   slave  : the reader's view (takes requests, drives radr, returns responses)
//   master : the environment's view (scheduler, data store and response sink)
// Signals:
//   req_*  : read request in (valid/ready, set, way, mask, tag)
//   radr_* : data-store read request out (valid/ready, set, way, mask)
//   rdat_* : data-store read data in, valid one cycle after radr fires
//   resp_* : response out (valid/ready, data, mask, tag)
//   busy_o : read in flight or response buffered
interface banked_store_reader_if #(
  parameter int SET_BITS        = 6,
  parameter int WAY_BITS        = 3,
  parameter int INNER_MASK_BITS = 4,
  parameter int TAG_W           = 8,
  parameter int DATA_W          = 128
);
  logic                       req_valid_i;
  logic                       req_ready_o;
  logic [SET_BITS-1:0]        req_set_i;
  logic [WAY_BITS-1:0]        req_way_i;
  logic [INNER_MASK_BITS-1:0] req_mask_i;
  logic [TAG_W-1:0]           req_tag_i;

  logic                       radr_valid_o;
  logic                       radr_ready_i;
  logic [SET_BITS-1:0]        radr_set_o;
  logic [WAY_BITS-1:0]        radr_way_o;
  logic [INNER_MASK_BITS-1:0] radr_mask_o;

  logic [DATA_W-1:0]          rdat_data_i;

  logic                       resp_valid_o;
  logic                       resp_ready_i;
  logic [DATA_W-1:0]          resp_data_o;
  logic [INNER_MASK_BITS-1:0] resp_mask_o;
  logic [TAG_W-1:0]           resp_tag_o;

  logic                       busy_o;

  modport slave (
    input  req_valid_i, req_set_i, req_way_i, req_mask_i, req_tag_i,
    output req_ready_o,
    output radr_valid_o, radr_set_o, radr_way_o, radr_mask_o,
    input  radr_ready_i,
    input  rdat_data_i,
    output resp_valid_o, resp_data_o, resp_mask_o, resp_tag_o,
    input  resp_ready_i,
    output busy_o
  );

  modport master (
    output req_valid_i, req_set_i, req_way_i, req_mask_i, req_tag_i,
    input  req_ready_o,
    input  radr_valid_o, radr_set_o, radr_way_o, radr_mask_o,
    output radr_ready_i,
    output rdat_data_i,
    input  resp_valid_o, resp_data_o, resp_mask_o, resp_tag_o,
    output resp_ready_i,
    input  busy_o
  );
endinterface

// File: rtl/banked_store_reader.sv
// rtl/banked_store_reader.sv - read-side initiator for the L2 banked data store
//
// Purpose: issues read requests on the data store read port, captures the beat
// returned one cycle later and delivers it with its tag and mask through a
// credit-managed output FIFO with valid/ready back-pressure.
// Ports:
//   clk   : clock, all state on posedge
//   rst_n : asynchronous active-low reset
//   bus   : banked_store_reader_if.slave (req_*, radr_*, rdat_*, resp_*, busy_o)
// Build option:
//   BANKED_STORE_READER_MASK_EN - when defined, CODE_BITS slices whose mask bit
//   is 0 are zeroed as the beat is written into the FIFO.
module banked_store_reader #(
  parameter int TAG_W              = 8,
  parameter int FIFO_DEPTH         = 2,
  parameter int SET_BITS           = 6,
  parameter int WAY_BITS           = 3,
  parameter int INNER_MASK_BITS    = 4,
  parameter int L2CACHE_WRITEBYTES = 4,
  parameter int L2CACHE_BEATBYTES  = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  banked_store_reader_if.slave bus
);
  localparam int NUM_BANKS = INNER_MASK_BITS;
  localparam int CODE_BITS = 8 * L2CACHE_WRITEBYTES;
  localparam int DATA_W    = L2CACHE_BEATBYTES * 8;
  localparam int PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W     = $clog2(FIFO_DEPTH + 1);

  logic [DATA_W-1:0]          fifo_data_q [FIFO_DEPTH];
  logic [NUM_BANKS-1:0]       fifo_mask_q [FIFO_DEPTH];
  logic [TAG_W-1:0]           fifo_tag_q  [FIFO_DEPTH];
  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]           count_q, count_d;
  logic                       inflight_q;
  logic [NUM_BANKS-1:0]       cap_mask_q;
  logic [TAG_W-1:0]           cap_tag_q;

  logic                       push;
  logic                       pop;
  logic                       credit;
  logic                       fire;
  logic [CNT_W:0]             occupancy;
  logic [DATA_W-1:0]          wr_data;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    ptr_inc = (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign push = inflight_q;
  assign pop  = bus.resp_valid_o & bus.resp_ready_i;

  // Reserve a slot for the beat still on its way from the data store so a
  // push can never land on a full FIFO; a same-cycle pop frees one slot.
  assign occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q} - {{CNT_W{1'b0}}, pop};
  assign credit    = occupancy < (CNT_W+1)'(FIFO_DEPTH);

  assign bus.req_ready_o  = credit & bus.radr_ready_i & rst_n;
  assign bus.radr_valid_o = bus.req_valid_i & credit & rst_n;
  assign fire             = bus.req_valid_i & bus.req_ready_o;

  assign bus.radr_set_o  = bus.req_set_i;
  assign bus.radr_way_o  = bus.req_way_i;
  assign bus.radr_mask_o = bus.req_mask_i;

  always_comb begin
    wr_data = bus.rdat_data_i;
`ifdef BANKED_STORE_READER_MASK_EN
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (!cap_mask_q[i]) begin
        wr_data[i*CODE_BITS +: CODE_BITS] = '0;
      end
    end
`endif
  end

  always_comb begin
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
      cap_mask_q <= '0;
      cap_tag_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_q[i] <= '0;
        fifo_mask_q[i] <= '0;
        fifo_tag_q[i]  <= '0;
      end
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      inflight_q <= fire;
      if (fire) begin
        cap_mask_q <= bus.req_mask_i;
        cap_tag_q  <= bus.req_tag_i;
      end
      if (push) begin
        fifo_data_q[wr_ptr_q] <= wr_data;
        fifo_mask_q[wr_ptr_q] <= cap_mask_q;
        fifo_tag_q[wr_ptr_q]  <= cap_tag_q;
      end
    end
  end

  assign bus.resp_valid_o = (count_q != '0);
  assign bus.resp_data_o  = fifo_data_q[rd_ptr_q];
  assign bus.resp_mask_o  = fifo_mask_q[rd_ptr_q];
  assign bus.resp_tag_o   = fifo_tag_q[rd_ptr_q];
  assign bus.busy_o       = inflight_q | (count_q != '0);
endmodule
